// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: ALU writeback vs. an in-order load-return queue.
// Optional load starvation bound when RFARB_STARVE_GUARD_EN is defined.
module rf_write_arbiter #(
    parameter int LQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iAluWe,
    input  logic [4:0]  iAluAddr,
    input  logic [31:0] iAluData,
    output logic        oAluStall,
    input  logic        iLdValid,
    input  logic [4:0]  iLdAddr,
    input  logic [31:0] iLdData,
    output logic        oLdReady,
    output logic        rf_we,
    output logic [4:0]  WAddr,
    output logic [31:0] WData
);
    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (LQ_DEPTH < 2 || (LQ_DEPTH & (LQ_DEPTH - 1)) != 0) begin : gDepthCheck
        $error("LQ_DEPTH must be a power of two, at least 2");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : gLimitCheck
        $error("STARVE_LIMIT must be in 1..15");
    end

    logic [4:0]       qAddr [LQ_DEPTH];
    logic [31:0]      qData [LQ_DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;
    logic             ldReadyR;

    logic             qNonEmpty;
    logic             push;
    logic             aluHit;
    logic             aluGrant;
    logic             ldGrant;
    logic             starveForce;

    logic             grantVld_p0;
    logic [4:0]       grantAddr_p0;
    logic [31:0]      grantData_p0;

    // An entry is live when its distance from the head is below the occupancy.
    function automatic logic entryLive(input logic [PTR_W-1:0] idx,
                                       input logic [PTR_W-1:0] head,
                                       input logic [CNT_W-1:0] occ);
        logic [PTR_W-1:0] offs;
        offs = idx - head;
        return {1'b0, offs} < occ;
    endfunction

    function automatic logic [3:0] satIncStarve(input logic [3:0] cnt);
        return (cnt >= 4'(STARVE_LIMIT)) ? 4'(STARVE_LIMIT) : cnt + 4'd1;
    endfunction

    assign qNonEmpty = (count != '0);
    assign push      = iLdValid && ldReadyR;
    assign oLdReady  = ldReadyR;

    // Only already-queued loads guard the ALU; the entry being pushed now is excluded.
    always_comb begin
        aluHit = 1'b0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (entryLive(PTR_W'(i), rdPtr, count) && (qAddr[i] == iAluAddr)) begin
                aluHit = 1'b1;
            end
        end
    end

`ifdef RFARB_STARVE_GUARD_EN
    logic [3:0] starveCnt;

    assign starveForce = qNonEmpty && (starveCnt == 4'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            starveCnt <= 4'd0;
        end else if (ldGrant || !qNonEmpty) begin
            starveCnt <= 4'd0;
        end else begin
            starveCnt <= satIncStarve(starveCnt);
        end
    end
`else
    assign starveForce = 1'b0;
`endif

    always_comb begin
        aluGrant = 1'b0;
        ldGrant  = 1'b0;
        if (starveForce) begin
            ldGrant = 1'b1;
        end else if (iAluWe && !aluHit) begin
            aluGrant = 1'b1;
        end else if (qNonEmpty) begin
            ldGrant = 1'b1;
        end
    end

    assign oAluStall = iAluWe && !aluGrant;

    always_comb begin
        grantVld_p0  = aluGrant || ldGrant;
        grantAddr_p0 = aluGrant ? iAluAddr : qAddr[rdPtr];
        grantData_p0 = aluGrant ? iAluData : qData[rdPtr];
    end

    always_comb begin
        countNext = count;
        case ({push, ldGrant})
            2'b10:   countNext = count + CNT_W'(1);
            2'b01:   countNext = count - CNT_W'(1);
            default: countNext = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            qAddr[wrPtr] <= iLdAddr;
            qData[wrPtr] <= iLdData;
        end
    end

    // ---- stage boundary: selected write -> register-file port ----
    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            ldReadyR <= 1'b0;
            rf_we    <= 1'b0;
            WAddr    <= 5'd0;
            WData    <= 32'd0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (ldGrant) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count    <= countNext;
            ldReadyR <= (countNext < CNT_W'(LQ_DEPTH));
            rf_we    <= grantVld_p0;
            if (grantVld_p0) begin
                WAddr <= grantAddr_p0;
                WData <= grantData_p0;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter; the starvation scenario runs when
// RFARB_STARVE_GUARD_EN is defined, the full-queue scenario otherwise.
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        iAluWe;
    logic [4:0]  iAluAddr;
    logic [31:0] iAluData;
    logic        oAluStall;
    logic        iLdValid;
    logic [4:0]  iLdAddr;
    logic [31:0] iLdData;
    logic        oLdReady;
    logic        rf_we;
    logic [4:0]  WAddr;
    logic [31:0] WData;

    int nChecks = 0;
    int nFails  = 0;

    rf_write_arbiter #(.LQ_DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset),
        .iAluWe(iAluWe), .iAluAddr(iAluAddr), .iAluData(iAluData), .oAluStall(oAluStall),
        .iLdValid(iLdValid), .iLdAddr(iLdAddr), .iLdData(iLdData), .oLdReady(oLdReady),
        .rf_we(rf_we), .WAddr(WAddr), .WData(WData)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkWrite(input string tag, input logic [4:0] a, input logic [31:0] d);
        checkEq({tag, "_we"}, 32'(rf_we), 32'd1);
        checkEq({tag, "_addr"}, 32'(WAddr), 32'(a));
        checkEq({tag, "_data"}, WData, d);
    endtask

    initial begin
        reset = 1'b1; iAluWe = 1'b0; iAluAddr = '0; iAluData = '0;
        iLdValid = 1'b0; iLdAddr = '0; iLdData = '0;
        step(); step();
        checkEq("rst_we", 32'(rf_we), 32'd0);
        checkEq("rst_waddr", 32'(WAddr), 32'd0);
        checkEq("rst_wdata", WData, 32'd0);
        checkEq("rst_ldready", 32'(oLdReady), 32'd0);
        reset = 1'b0;
        step();
        checkEq("post_rst_ldready", 32'(oLdReady), 32'd1);

        // ALU only
        iAluWe = 1'b1; iAluAddr = 5'd5; iAluData = 32'hDEADBEEF;
        #1 checkEq("alu_stall", 32'(oAluStall), 32'd0);
        step();
        checkWrite("alu", 5'd5, 32'hDEADBEEF);
        iAluWe = 1'b0;
        step();
        checkEq("idle_we", 32'(rf_we), 32'd0);
        checkEq("idle_hold_addr", 32'(WAddr), 32'd5);

        // Load with ALU idle: two cycles to rf_we
        iLdValid = 1'b1; iLdAddr = 5'd7; iLdData = 32'h1234;
        step();
        iLdValid = 1'b0;
        checkEq("ld_push_we", 32'(rf_we), 32'd0);
        checkEq("ld_ready", 32'(oLdReady), 32'd1);
        step();
        checkWrite("ld", 5'd7, 32'h1234);
        checkEq("ld_ready2", 32'(oLdReady), 32'd1);
        step();
        checkEq("ld_done_we", 32'(rf_we), 32'd0);

        // WAW guard
        iLdValid = 1'b1; iLdAddr = 5'd9; iLdData = 32'hA;
        step();
        iLdValid = 1'b0;
        iAluWe = 1'b1; iAluAddr = 5'd9; iAluData = 32'hB;
        #1 checkEq("waw_stall", 32'(oAluStall), 32'd1);
        step();
        checkWrite("waw_ld", 5'd9, 32'hA);
        checkEq("waw_unstall", 32'(oAluStall), 32'd0);
        step();
        checkWrite("waw_alu", 5'd9, 32'hB);

        // Address 0 passes through
        iAluAddr = 5'd0; iAluData = 32'h55;
        step();
        checkWrite("r0", 5'd0, 32'h55);
        iAluWe = 1'b0;
        step();

`ifdef RFARB_STARVE_GUARD_EN
        // One load behind continuous ALU writes to r2
        for (int c = 0; c < 6; c++) begin
            iAluWe = 1'b1; iAluAddr = 5'd2; iAluData = 32'h200 + 32'(c);
            iLdValid = (c == 0); iLdAddr = 5'd20; iLdData = 32'h77;
            #1 checkEq($sformatf("starve_stall_%0d", c), 32'(oAluStall), 32'(c == 4));
            step();
            if (c == 4) checkWrite("starve_ld", 5'd20, 32'h77);
            else        checkWrite($sformatf("starve_alu_%0d", c), 5'd2, 32'h200 + 32'(c));
        end
        iAluWe = 1'b0; iLdValid = 1'b0;
        step();
`else
        // Fill the queue behind strict-priority ALU traffic
        for (int i = 0; i < 5; i++) begin
            iAluWe = 1'b1; iAluAddr = 5'd1; iAluData = 32'(i);
            iLdValid = 1'b1; iLdAddr = 5'(10 + i); iLdData = 32'(100 + i);
            #1 checkEq($sformatf("fill_ready_%0d", i), 32'(oLdReady), 32'(i < 4));
            step();
            checkWrite($sformatf("fill_alu_%0d", i), 5'd1, 32'(i));
        end
        iAluData = 32'd5;
        #1 checkEq("full_ready", 32'(oLdReady), 32'd0);
        step();
        iAluWe = 1'b0;
        #1 checkEq("pop_ready", 32'(oLdReady), 32'd0);
        step();
        checkWrite("drain0", 5'd10, 32'd100);
        checkEq("reopen_ready", 32'(oLdReady), 32'd1);
        step();
        iLdValid = 1'b0;
        checkWrite("drain1", 5'd11, 32'd101);
        step();
        checkWrite("drain2", 5'd12, 32'd102);
        step();
        checkWrite("drain3", 5'd13, 32'd103);
        step();
        checkWrite("drain4", 5'd14, 32'd104);
        step();
        checkEq("drained_we", 32'(rf_we), 32'd0);
`endif

        // Reset with three loads queued
        for (int i = 0; i < 3; i++) begin
            iAluWe = 1'b1; iAluAddr = 5'd3; iAluData = 32'h300 + 32'(i);
            iLdValid = 1'b1; iLdAddr = 5'(21 + i); iLdData = 32'h400 + 32'(i);
            #1 checkEq($sformatf("rq_stall_%0d", i), 32'(oAluStall), 32'd0);
            step();
        end
        iLdValid = 1'b0; reset = 1'b1;
        step();
        checkEq("mid_rst_we", 32'(rf_we), 32'd0);
        checkEq("mid_rst_ready", 32'(oLdReady), 32'd0);
        reset = 1'b0; iAluWe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checkEq($sformatf("after_rst_we_%0d", i), 32'(rf_we), 32'd0);
        end
        checkEq("after_rst_ready", 32'(oLdReady), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
